uart_wb_sequencer: RTL and testbench



---
 rtl/uart_seq_pkg.sv | 50 +++++
 rtl/uart_wb_access.sv | 79 +++++++
 rtl/uart_wb_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_uart_wb_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART Wishbone sequencer: UART register map,
// LSR bit positions, sequencer states and the init write table.
package uart_seq_pkg;

    localparam logic [7:0] RBR_THR = 8'd0;
    localparam logic [7:0] IER     = 8'd1;
    localparam logic [7:0] DLM     = 8'd1;
    localparam logic [7:0] FCR     = 8'd2;
    localparam logic [7:0] LCR     = 8'd3;
    localparam logic [7:0] LSR     = 8'd5;
    localparam logic [7:0] DLL     = 8'd0;

    localparam int DR_BIT   = 0;
    localparam int THRE_BIT = 5;

    localparam logic [2:0] INIT_LAST_STEP = 3'd5;

    typedef enum logic [2:0] {
        INIT,
        GAP,
        POLL,
        DECIDE,
        RD_RBR,
        WR_THR,
        ERR
    } seq_state_e;

    typedef struct packed {
        logic [7:0] adr;
        logic [7:0] dat;
    } reg_wr_t;

    // Init order: open divisor latch, load divisor, close latch, FIFOs, IRQs off.
    function automatic reg_wr_t init_write(input logic [2:0]  step,
                                           input logic [15:0] divisor,
                                           input logic [7:0]  lcr,
                                           input logic [7:0]  fcr);
        reg_wr_t w;
        case (step)
            3'd0:    w = '{adr: LCR, dat: 8'h80 | lcr};
            3'd1:    w = '{adr: DLL, dat: divisor[7:0]};
            3'd2:    w = '{adr: DLM, dat: divisor[15:8]};
            3'd3:    w = '{adr: LCR, dat: lcr};
            3'd4:    w = '{adr: FCR, dat: fcr};
            default: w = '{adr: IER, dat: 8'h00};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/uart_wb_access.sv
// Single-access Wishbone classic master engine with an ack timeout.
// Bus signals are registered; done/timeout are single-cycle strobes.
module uart_wb_access
    import uart_seq_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [7:0]        wdat_i,
    output logic              done_o,
    output logic [7:0]        rdat_o,
    output logic              timeout_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [7:0]        wbm_dat_o,
    input  logic [7:0]        wbm_dat_i,
    output logic              wbm_we_o,
    output logic              wbm_stb_o,
    output logic              wbm_cyc_o,
    output logic [3:0]        wbm_sel_o,
    input  logic              wbm_ack_i
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic              cyc_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [7:0]        dat_q;
    logic [7:0]        cnt_q;
    logic              expire;

    // The cycle counted as LAST_CNT is the final one cyc may stay high unanswered.
    assign expire = cyc_q & ~wbm_ack_i & (cnt_q == LAST_CNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else if (!cyc_q) begin
            cnt_q <= '0;
            if (start_i) begin
                cyc_q <= 1'b1;
                we_q  <= we_i;
                adr_q <= adr_i;
                dat_q <= wdat_i;
            end
        end else if (wbm_ack_i || expire) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign done_o    = cyc_q & wbm_ack_i;
    assign timeout_o = expire;
    assign rdat_o    = wbm_dat_i;
    assign busy_o    = cyc_q;

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = {3'b000, cyc_q};

endmodule

// File: rtl/uart_wb_sequencer.sv
// Wishbone master for uart_top: programs the UART after reset, then polls
// LSR and moves bytes between the tx/rx streams and THR/RBR.
module uart_wb_sequencer
    import uart_seq_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_VAL  = 8'h03,
    parameter logic [7:0]  FCR_VAL  = 8'hC7,
    parameter int          TIMEOUT  = 255,
    parameter int          POLL_GAP = 15
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [7:0]        wbm_dat_o,
    input  logic [7:0]        wbm_dat_i,
    output logic              wbm_we_o,
    output logic              wbm_stb_o,
    output logic              wbm_cyc_o,
    output logic [3:0]        wbm_sel_o,
    input  logic              wbm_ack_i,
    input  logic [7:0]        tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              init_done,
    output logic              bus_err
);

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    seq_state_e state_q;
    logic [2:0] step_q;
    logic [7:0] gap_q;
    logic       dr_q;
    logic       thre_q;
    logic       last_rx_q;
    logic       rx_valid_q;
    logic [7:0] rx_data_q;
    logic       init_done_q;
    logic       bus_err_q;

    logic              acc_start;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_adr;
    logic [7:0]        acc_wdat;
    logic              acc_done;
    logic [7:0]        acc_rdat;
    logic              acc_timeout;
    logic              acc_busy;

    reg_wr_t iw;
    logic    rx_elig;
    logic    tx_elig;

    assign iw      = init_write(step_q, DIVISOR, LCR_VAL, FCR_VAL);
    assign rx_elig = dr_q & ~rx_valid_q;
    assign tx_elig = thre_q & tx_valid;

    // Each access state requests exactly one access: start is only offered while the engine is idle.
    always_comb begin
        acc_start = 1'b0;
        acc_we    = 1'b0;
        acc_adr   = '0;
        acc_wdat  = '0;
        case (state_q)
            INIT: begin
                acc_start = ~acc_busy;
                acc_we    = 1'b1;
                acc_adr   = ADDR_W'(iw.adr);
                acc_wdat  = iw.dat;
            end
            POLL: begin
                acc_start = ~acc_busy;
                acc_adr   = ADDR_W'(LSR);
            end
            RD_RBR: begin
                acc_start = ~acc_busy;
                acc_adr   = ADDR_W'(RBR_THR);
            end
            WR_THR: begin
                acc_start = ~acc_busy;
                acc_we    = 1'b1;
                acc_adr   = ADDR_W'(RBR_THR);
                acc_wdat  = tx_data;
            end
            default: ;
        endcase
    end

    uart_wb_access #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_access (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .start_i   (acc_start),
        .we_i      (acc_we),
        .adr_i     (acc_adr),
        .wdat_i    (acc_wdat),
        .done_o    (acc_done),
        .rdat_o    (acc_rdat),
        .timeout_o (acc_timeout),
        .busy_o    (acc_busy),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_we_o  (wbm_we_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_ack_i (wbm_ack_i)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= INIT;
            step_q      <= '0;
            gap_q       <= '0;
            dr_q        <= 1'b0;
            thre_q      <= 1'b0;
            last_rx_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            init_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (acc_timeout) begin
                bus_err_q <= 1'b1;
                state_q   <= ERR;
            end else begin
                case (state_q)
                    INIT: begin
                        if (acc_done) begin
                            if (step_q == INIT_LAST_STEP) begin
                                init_done_q <= 1'b1;
                                state_q     <= GAP;
                            end else begin
                                step_q <= step_q + 3'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_q == GAP_LAST) begin
                            gap_q   <= '0;
                            state_q <= POLL;
                        end else begin
                            gap_q <= gap_q + 8'd1;
                        end
                    end
                    POLL: begin
                        if (acc_done) begin
                            dr_q    <= acc_rdat[DR_BIT];
                            thre_q  <= acc_rdat[THRE_BIT];
                            state_q <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        // On contention, serve whichever direction was not served last.
                        if (rx_elig && (!tx_elig || !last_rx_q)) begin
                            state_q <= RD_RBR;
                        end else if (tx_elig) begin
                            state_q <= WR_THR;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                    RD_RBR: begin
                        if (acc_done) begin
                            rx_data_q  <= acc_rdat;
                            rx_valid_q <= 1'b1;
                            last_rx_q  <= 1'b1;
                            state_q    <= GAP;
                        end
                    end
                    WR_THR: begin
                        if (acc_done) begin
                            last_rx_q <= 1'b0;
                            state_q   <= GAP;
                        end
                    end
                    default: state_q <= ERR;
                endcase
            end
        end
    end

    assign tx_ready  = (state_q == WR_THR) & acc_done;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Self-checking bench for uart_wb_sequencer: Wishbone slave with random LSR/RBR
// responses and a transaction-level model of the expected access sequence.
module tb_uart_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] adr;
    logic [7:0] dat_o;
    logic [7:0] dat_i = 8'h00;
    logic       we, stb, cyc, ack = 1'b0;
    logic [3:0] sel;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       txr;
    logic [7:0] rxd;
    logic       rxv;
    logic       rx_ready = 1'b0;
    logic       idone, berr;

    always #5 clk = ~clk;

    uart_wb_sequencer dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_we_o  (we),
        .wbm_stb_o (stb),
        .wbm_cyc_o (cyc),
        .wbm_sel_o (sel),
        .wbm_ack_i (ack),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (txr),
        .rx_data   (rxd),
        .rx_valid  (rxv),
        .rx_ready  (rx_ready),
        .init_done (idone),
        .bus_err   (berr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected init writes for DIVISOR=27 (0x1B), LCR_VAL=03, FCR_VAL=C7.
    logic [7:0] init_adr [6] = '{8'd3, 8'd0, 8'd1, 8'd3, 8'd2, 8'd1};
    logic [7:0] init_dat [6] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'hC7, 8'h00};

    int  cyc_n = 0;
    int  acc_idx = 0, cur_idx = 0, wcnt = 0, wlim = 0, done_exp = -1;
    int  stall_idx = -1, run_len = 0, last_run = 0;
    bit  in_acc = 0, seen_done = 0, contend = 0, stall_thr = 0;
    logic [4:0] cur_adr;
    logic       cur_we;
    int  exp_kind = 0;              // 0: LSR poll, 1: RBR read, 2: THR write
    logic [7:0] exp_tx = 8'h00;
    bit  model_rxv = 0, last_rx = 0;
    logic [7:0] rxq [$];

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        logic [7:0] lsr, b;
        bit rxe, txe, rr;
        if (cyc) run_len++;
        else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (rst) begin
            ack = 0; in_acc = 0; acc_idx = 0; seen_done = 0;
            model_rxv = 0; last_rx = 0; exp_kind = 0;
            tx_valid = 0; rx_ready = 0; rxq.delete();
        end else if (ack) begin
            ack = 0;
            in_acc = 0;
            chk("cyc_drop_after_ack", cyc, 0);
            if (cur_we && cur_adr == 5'd0 && cur_idx >= 6) tx_valid = 0;
        end else if (cyc) begin
            if (!in_acc) begin
                in_acc  = 1;
                wcnt    = 0;
                cur_idx = acc_idx;
                acc_idx++;
                cur_adr = adr;
                cur_we  = we;
                wlim    = (cur_idx < 6) ? 2 : int'($urandom_range(0, 3));
                chk("sel", sel, 4'b0001);
                chk("stb", stb, 1);
                if (cur_idx < 6) begin
                    chk("init_adr", adr, init_adr[cur_idx]);
                    chk("init_dat", dat_o, init_dat[cur_idx]);
                    chk("init_we", we, 1);
                end else begin
                    case (exp_kind)
                        0: begin chk("poll_adr", adr, 5); chk("poll_we", we, 0); end
                        1: begin chk("rbr_adr", adr, 0); chk("rbr_we", we, 0); end
                        default: begin
                            chk("thr_adr", adr, 0); chk("thr_we", we, 1);
                            chk("thr_dat", dat_o, exp_tx);
                        end
                    endcase
                end
            end
            if (cur_idx == stall_idx || (stall_thr && cur_we && cur_adr == 5'd0 && cur_idx >= 6)) begin
                wcnt = wcnt;
            end else if (wcnt >= wlim) begin
                ack = 1;
                dat_i = 8'h00;
                if (cur_idx == 5) done_exp = cyc_n + 1;
                if (cur_idx >= 6) begin
                    case (exp_kind)
                        0: begin
                            lsr = contend ? 8'h21 : 8'($urandom);
                            dat_i = lsr;
                            rr = contend ? 1'b1 : 1'($urandom_range(0, 1));
                            rx_ready = rr;
                            if (rr) model_rxv = 0;
                            if (!tx_valid && (contend || $urandom_range(0, 1) == 1)) begin
                                tx_valid = 1;
                                tx_data  = 8'($urandom);
                            end
                            rxe = lsr[0] && !model_rxv;
                            txe = lsr[5] && tx_valid;
                            exp_tx = tx_data;
                            if (rxe && txe) exp_kind = last_rx ? 2 : 1;
                            else if (rxe)   exp_kind = 1;
                            else if (txe)   exp_kind = 2;
                            else            exp_kind = 0;
                        end
                        1: begin
                            b = 8'($urandom);
                            dat_i = b;
                            rxq.push_back(b);
                            model_rxv = !rx_ready;
                            last_rx = 1;
                            exp_kind = 0;
                        end
                        default: begin
                            last_rx = 0;
                            exp_kind = 0;
                        end
                    endcase
                end
            end else begin
                wcnt++;
                // Producer may withdraw mid-access; the byte must still go out.
                if (cur_idx >= 6 && cur_we && $urandom_range(0, 3) == 0) tx_valid = 0;
            end
        end else begin
            in_acc = 0;
        end
        #1;
        if (!rst) begin
            if (ack) chk("tx_ready_on_ack", txr, (cur_we && cur_adr == 5'd0 && cur_idx >= 6));
            if (rxv && rx_ready) begin
                if (rxq.size() == 0) chk("rx_unexpected", 1, 0);
                else chk("rx_data", rxd, rxq.pop_front());
            end
            if (idone && !seen_done) begin
                seen_done = 1;
                chk("init_done_cycle", cyc_n, done_exp);
            end
        end
    end

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget && acc_idx < n; i++) @(negedge clk);
        chk("wait_accesses", (acc_idx >= n), 1);
    endtask

    initial begin
        bit found;
        int quiet;
        rst = 1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_sel", sel, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_tx_ready", txr, 0);
        chk("rst_rx_valid", rxv, 0);
        chk("rst_rx_data", rxd, 0);
        chk("rst_init_done", idone, 0);
        chk("rst_bus_err", berr, 0);
        rst = 0;

        wait_acc(70, 20000);
        chk("init_done_high", idone, 1);
        chk("init_done_seen", seen_done, 1);

        contend = 1;
        wait_acc(90, 8000);

        stall_thr = 1;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (cyc && we && adr == 5'd0) found = 1;
        end
        chk("thr_write_seen", found, 1);
        #2 rst = 1;
        #1;
        chk("midrst_cyc", cyc, 0);
        chk("midrst_stb", stb, 0);
        chk("midrst_tx_ready", txr, 0);
        repeat (3) @(negedge clk);
        stall_thr = 0;
        contend = 0;
        #2 rst = 0;
        wait_acc(7, 3000);
        chk("reinit_done", idone, 1);

        @(negedge clk);
        #2 rst = 1;
        stall_idx = 1;
        repeat (3) @(negedge clk);
        #2 rst = 0;
        for (int i = 0; i < 1000 && !berr; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("timeout_cyc_len", last_run, 255);
        chk("timeout_bus_err", berr, 1);
        chk("timeout_init_done", idone, 0);
        quiet = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cyc) quiet++;
        end
        chk("err_no_cyc", quiet, 0);
        chk("err_bus_err_sticky", berr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
